// File: rtl/memory_controller_seq.sv
// memory_controller_seq
// Sequential virtual-to-physical memory controller. One CPU access at a time
// is accepted over a req/ready handshake, decoded into the text, data-segment
// or IO region, and carried out against RAM (fixed wait states) or the IO bus
// (ready handshake with timeout). Every output comes straight from a register.

module memory_controller_seq #(
    parameter logic [31:0] VIRT_TEXT_START = 32'h0000_0000,
    parameter logic [31:0] VIRT_TEXT_END   = 32'h0fff_ffff,
    parameter logic [31:0] VIRT_DS_START   = 32'h1000_0000,
    parameter logic [31:0] VIRT_DS_END     = 32'h7fff_ffff,
    parameter logic [31:0] VIRT_IO_START   = 32'hffff_0000,
    parameter logic [31:0] VIRT_IO_END     = 32'hffff_ffff,
    parameter int          PHYS_ADDR_BITS  = 11,
    parameter int          IO_ADDR_BITS    = 4,
    parameter int          DS_OFFSET_SHIFT = 1,
    parameter int          MEM_WAIT        = 1,
    parameter int          IO_TIMEOUT      = 15,
    parameter int          WAIT_BITS       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reqVirt,
    input  logic                      wEnVirt,
    input  logic [31:0]               addressVirt,
    input  logic [31:0]               dataInVirt,
    output logic [31:0]               dataOutVirt,
    output logic                      readyVirt,
    output logic                      errVirt,
    output logic [PHYS_ADDR_BITS-1:0] addressPhys,
    output logic [31:0]               dataInPhys,
    input  logic [31:0]               dataOutPhys,
    output logic                      enPhys,
    output logic                      wEnPhys,
    output logic [IO_ADDR_BITS-1:0]   addressIO,
    output logic [31:0]               dataInIO,
    input  logic [31:0]               dataOutIO,
    output logic                      enIO,
    output logic                      wEnIO,
    input  logic                      readyIO
);

    // Region spans are stored as (end - start) so an inclusive range check
    // becomes a single unsigned compare of (addr - start) against the span.
    localparam logic [31:0] TEXT_SPAN = VIRT_TEXT_END - VIRT_TEXT_START;
    localparam logic [31:0] DS_SPAN   = VIRT_DS_END - VIRT_DS_START;
    localparam logic [31:0] IO_SPAN   = VIRT_IO_END - VIRT_IO_START;
    localparam logic [31:0] DS_BASE   = 32'((2 ** PHYS_ADDR_BITS) >> DS_OFFSET_SHIFT);

    localparam logic [WAIT_BITS-1:0] MEM_LAST = WAIT_BITS'(MEM_WAIT);
    localparam logic [WAIT_BITS-1:0] IO_LAST  = WAIT_BITS'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        IO,
        DONE
    } state_t;

    state_t                    state_q;
    logic [WAIT_BITS-1:0]      count_q;
    logic                      wEn_q;
    logic [31:0]               dataOut_q;
    logic                      ready_q;
    logic                      err_q;
    logic [PHYS_ADDR_BITS-1:0] addrPhys_q;
    logic [31:0]               dinPhys_q;
    logic                      enPhys_q;
    logic                      wEnPhys_q;
    logic [IO_ADDR_BITS-1:0]   addrIo_q;
    logic [31:0]               dinIo_q;
    logic                      enIo_q;
    logic                      wEnIo_q;

    logic [31:0]               textOff_d;
    logic [31:0]               dsOff_d;
    logic [31:0]               ioOff_d;
    logic                      hitText_d;
    logic                      hitDs_d;
    logic                      hitIo_d;
    logic [PHYS_ADDR_BITS-1:0] memAddr_d;
    logic [IO_ADDR_BITS-1:0]   ioAddr_d;

    // Decode the incoming virtual address into region hits and the RAM / IO
    // addresses it would map to; only consulted when a request is accepted.
    always_comb begin
        textOff_d = addressVirt - VIRT_TEXT_START;
        dsOff_d   = addressVirt - VIRT_DS_START;
        ioOff_d   = addressVirt - VIRT_IO_START;
        hitText_d = (textOff_d <= TEXT_SPAN);
        hitDs_d   = (dsOff_d <= DS_SPAN);
        hitIo_d   = (ioOff_d <= IO_SPAN);
        if (hitText_d) begin
            memAddr_d = PHYS_ADDR_BITS'(textOff_d);
        end else begin
            memAddr_d = PHYS_ADDR_BITS'(dsOff_d + DS_BASE);
        end
        ioAddr_d = IO_ADDR_BITS'(ioOff_d);
    end

    // Access sequencer: accepts a request, runs the RAM or IO phase, and
    // presents a one-cycle completion with registered data and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wEn_q      <= 1'b0;
            dataOut_q  <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            addrPhys_q <= '0;
            dinPhys_q  <= '0;
            enPhys_q   <= 1'b0;
            wEnPhys_q  <= 1'b0;
            addrIo_q   <= '0;
            dinIo_q    <= '0;
            enIo_q     <= 1'b0;
            wEnIo_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqVirt) begin
                        wEn_q   <= wEnVirt;
                        count_q <= '0;
                        if (hitText_d || hitDs_d) begin
                            state_q    <= MEM;
                            enPhys_q   <= 1'b1;
                            wEnPhys_q  <= wEnVirt;
                            addrPhys_q <= memAddr_d;
                            dinPhys_q  <= dataInVirt;
                        end else if (hitIo_d) begin
                            state_q  <= IO;
                            enIo_q   <= 1'b1;
                            wEnIo_q  <= wEnVirt;
                            addrIo_q <= ioAddr_d;
                            dinIo_q  <= dataInVirt;
                        end else begin
                            state_q   <= DONE;
                            ready_q   <= 1'b1;
                            err_q     <= 1'b1;
                            dataOut_q <= '0;
                        end
                    end
                end
                MEM: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == MEM_LAST) begin
                        dataOut_q  <= wEn_q ? 32'h0 : dataOutPhys;
                        err_q      <= 1'b0;
                        ready_q    <= 1'b1;
                        enPhys_q   <= 1'b0;
                        wEnPhys_q  <= 1'b0;
                        addrPhys_q <= '0;
                        dinPhys_q  <= '0;
                        state_q    <= DONE;
                    end
                end
                IO: begin
                    count_q <= count_q + 1'b1;
                    if (readyIO || (count_q == IO_LAST)) begin
                        dataOut_q <= (readyIO && !wEn_q) ? dataOutIO : 32'h0;
                        err_q     <= !readyIO;
                        ready_q   <= 1'b1;
                        enIo_q    <= 1'b0;
                        wEnIo_q   <= 1'b0;
                        addrIo_q  <= '0;
                        dinIo_q   <= '0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    ready_q   <= 1'b0;
                    err_q     <= 1'b0;
                    dataOut_q <= '0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dataOutVirt = dataOut_q;
    assign readyVirt   = ready_q;
    assign errVirt     = err_q;
    assign addressPhys = addrPhys_q;
    assign dataInPhys  = dinPhys_q;
    assign enPhys      = enPhys_q;
    assign wEnPhys     = wEnPhys_q;
    assign addressIO   = addrIo_q;
    assign dataInIO    = dinIo_q;
    assign enIO        = enIo_q;
    assign wEnIO       = wEnIo_q;

endmodule

// File: tb/tb_memory_controller_seq.sv
// tb_memory_controller_seq
// Drives CPU accesses into memory_controller_seq with a modelled RAM and IO
// peripheral and compares completions against a region/latency reference.

module tb_memory_controller_seq;

    localparam logic [31:0] TS  = 32'h0000_0000;
    localparam logic [31:0] TE  = 32'h0fff_ffff;
    localparam logic [31:0] DSS = 32'h1000_0000;
    localparam logic [31:0] DSE = 32'h7fff_ffff;
    localparam logic [31:0] IOS = 32'hffff_0000;
    localparam logic [31:0] IOE = 32'hffff_ffff;
    localparam int PAB = 11;
    localparam int IAB = 4;
    localparam int DSHIFT = 1;
    localparam int MEM_WAIT = 1;
    localparam int IO_TIMEOUT = 15;
    localparam int BOUND = 40;
    localparam longint PHYS_SIZE = longint'(1) << PAB;
    localparam longint DS_BASE = PHYS_SIZE >> DSHIFT;

    logic clk = 1'b0;
    logic rst;
    logic reqVirt, wEnVirt, readyIO;
    logic [31:0] addressVirt, dataInVirt, dataOutIO, dataOutPhys;
    logic [31:0] dataOutVirt, dataInPhys, dataInIO;
    logic readyVirt, errVirt, enPhys, wEnPhys, enIO, wEnIO;
    logic [PAB-1:0] addressPhys;
    logic [IAB-1:0] addressIO;

    int checks = 0;
    int errors = 0;

    memory_controller_seq #(
        .VIRT_TEXT_START(TS), .VIRT_TEXT_END(TE),
        .VIRT_DS_START(DSS), .VIRT_DS_END(DSE),
        .VIRT_IO_START(IOS), .VIRT_IO_END(IOE),
        .PHYS_ADDR_BITS(PAB), .IO_ADDR_BITS(IAB), .DS_OFFSET_SHIFT(DSHIFT),
        .MEM_WAIT(MEM_WAIT), .IO_TIMEOUT(IO_TIMEOUT), .WAIT_BITS(4)
    ) dut (
        .clk(clk), .rst(rst), .reqVirt(reqVirt), .wEnVirt(wEnVirt),
        .addressVirt(addressVirt), .dataInVirt(dataInVirt),
        .dataOutVirt(dataOutVirt), .readyVirt(readyVirt), .errVirt(errVirt),
        .addressPhys(addressPhys), .dataInPhys(dataInPhys), .dataOutPhys(dataOutPhys),
        .enPhys(enPhys), .wEnPhys(wEnPhys), .addressIO(addressIO),
        .dataInIO(dataInIO), .dataOutIO(dataOutIO), .enIO(enIO), .wEnIO(wEnIO),
        .readyIO(readyIO)
    );

    always #5 clk = ~clk;

    // RAM peripheral: unwritten words read back a per-address pattern.
    function automatic logic [31:0] seedFn(input logic [PAB-1:0] a);
        return {a, 5'h15, ~a, 5'h0a};
    endfunction

    bit [31:0] ram [0:2047];
    bit        ramWritten [0:2047];
    bit        useOverride = 1'b0;
    logic [31:0] physOverride = 32'h0;

    assign dataOutPhys = (enPhys !== 1'b1) ? 32'hbad0_bad0 :
                         useOverride ? physOverride :
                         (ramWritten[addressPhys] ? ram[addressPhys] : seedFn(addressPhys));

    always @(posedge clk) begin
        if (enPhys === 1'b1 && wEnPhys === 1'b1) begin
            ram[addressPhys]        <= dataInPhys;
            ramWritten[addressPhys] <= 1'b1;
        end
    end

    // Reference model: memory contents plus region/address rules.
    logic [31:0] refMem [0:2047];

    function automatic int regionOf(input logic [31:0] a);
        longint la;
        la = longint'(a);
        if (la >= longint'(TS) && la <= longint'(TE)) return 0;
        if (la >= longint'(DSS) && la <= longint'(DSE)) return 1;
        if (la >= longint'(IOS) && la <= longint'(IOE)) return 2;
        return 3;
    endfunction

    function automatic logic [PAB-1:0] physOf(input logic [31:0] a, input int region);
        longint off;
        if (region == 0) off = longint'(a) - longint'(TS);
        else off = longint'(a) - longint'(DSS) + DS_BASE;
        return PAB'(off % PHYS_SIZE);
    endfunction

    function automatic logic [IAB-1:0] ioOf(input logic [31:0] a);
        return IAB'((longint'(a) - longint'(IOS)) % 16);
    endfunction

    // Observations gathered by runAccess for the calling test to judge.
    int obsReadyCycle, obsMemCycles, obsIoCycles;
    logic [31:0] obsDataOut, obsPhysDin, obsIoDin;
    logic obsErr, obsPhysWe, obsIoWe;
    logic [PAB-1:0] obsPhysAddr;
    logic [IAB-1:0] obsIoAddr;
    bit obsOverlap, obsHoldBad, obsEnAtReady, obsCleared, obsTimedOut;

    // Performs one CPU access starting just after a clock edge in IDLE.
    // readyAt = enIO cycle in which readyIO is raised (0 = never).
    task automatic runAccess(input logic [31:0] addr, input logic we, input logic [31:0] din,
                             input int readyAt, input logic [31:0] ioData);
        bit done;
        obsReadyCycle = 0; obsMemCycles = 0; obsIoCycles = 0;
        obsDataOut = 'x; obsErr = 1'bx; obsPhysAddr = '0; obsPhysWe = 0; obsPhysDin = '0;
        obsIoAddr = '0; obsIoWe = 0; obsIoDin = '0;
        obsOverlap = 0; obsHoldBad = 0; obsEnAtReady = 0; obsCleared = 0; obsTimedOut = 0;
        addressVirt = addr; wEnVirt = we; dataInVirt = din; reqVirt = 1'b1;
        readyIO = 1'b0; dataOutIO = $urandom;
        done = 0;
        for (int cyc = 1; cyc <= BOUND && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                addressVirt = $urandom; dataInVirt = $urandom; wEnVirt = 1'($urandom);
            end
            readyIO = 1'b0; dataOutIO = $urandom;
            if (enPhys === 1'b1 && enIO === 1'b1) obsOverlap = 1;
            if (enPhys === 1'b1) begin
                if (obsMemCycles == 0) begin
                    obsPhysAddr = addressPhys; obsPhysWe = wEnPhys; obsPhysDin = dataInPhys;
                end else if (addressPhys !== obsPhysAddr || wEnPhys !== obsPhysWe ||
                             dataInPhys !== obsPhysDin) begin
                    obsHoldBad = 1;
                end
                obsMemCycles++;
            end
            if (enIO === 1'b1) begin
                if (obsIoCycles == 0) begin
                    obsIoAddr = addressIO; obsIoWe = wEnIO; obsIoDin = dataInIO;
                end
                obsIoCycles++;
                if (obsIoCycles == readyAt) begin
                    readyIO = 1'b1; dataOutIO = ioData;
                end
            end
            if (readyVirt === 1'b1) begin
                obsReadyCycle = cyc; obsDataOut = dataOutVirt; obsErr = errVirt;
                if (enPhys !== 1'b0 || enIO !== 1'b0) obsEnAtReady = 1;
                reqVirt = 1'b0;
                done = 1;
            end
        end
        reqVirt = 1'b0;
        if (!done) obsTimedOut = 1;
        else begin
            @(posedge clk); #1;
            obsCleared = (readyVirt === 1'b0 && dataOutVirt === 32'h0 && errVirt === 1'b0 &&
                          enPhys === 1'b0 && enIO === 1'b0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({readyVirt, errVirt, enPhys, wEnPhys, enIO, wEnIO} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {readyVirt, errVirt, enPhys, wEnPhys, enIO, wEnIO});
        end
        checks++;
        if ({dataOutVirt, addressPhys, dataInPhys, addressIO, dataInIO} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got dOut=%h aP=%h dP=%h aIO=%h dIO=%h expected all 0",
                     dataOutVirt, addressPhys, dataInPhys, addressIO, dataInIO);
        end
        rst = 1'b0;
    endtask

    task automatic test_text_read;
        useOverride = 1'b1; physOverride = 32'hdead_beef;
        runAccess(32'h0000_0010, 1'b0, 32'h0, 0, 32'h0);
        useOverride = 1'b0;
        checks++;
        if (obsPhysAddr !== 11'h010 || obsMemCycles != 2 || obsPhysWe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL text_phys: got addr=%h cycles=%0d we=%b expected 010/2/0",
                     obsPhysAddr, obsMemCycles, obsPhysWe);
        end
        checks++;
        if (obsReadyCycle != 3 || obsDataOut !== 32'hdead_beef || obsErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL text_result: got cyc=%0d data=%h err=%b expected 3/deadbeef/0",
                     obsReadyCycle, obsDataOut, obsErr);
        end
        checks++;
        if (!obsCleared || obsIoCycles != 0 || obsEnAtReady) begin
            errors++;
            $display("[TB] FAIL text_after: got cleared=%0d io=%0d enAtReady=%0d expected 1/0/0",
                     obsCleared, obsIoCycles, obsEnAtReady);
        end
    endtask

    task automatic test_ds_write;
        runAccess(32'h1000_0004, 1'b1, 32'h1234_5678, 0, 32'h0);
        refMem[11'h404] = 32'h1234_5678;
        checks++;
        if (obsPhysAddr !== 11'h404 || obsPhysWe !== 1'b1 || obsPhysDin !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL ds_write_phys: got addr=%h we=%b din=%h expected 404/1/12345678",
                     obsPhysAddr, obsPhysWe, obsPhysDin);
        end
        checks++;
        if (obsReadyCycle != MEM_WAIT + 2 || obsErr !== 1'b0 || obsDataOut !== 32'h0 ||
            obsIoCycles != 0) begin
            errors++;
            $display("[TB] FAIL ds_write_result: got cyc=%0d err=%b data=%h io=%0d expected %0d/0/0/0",
                     obsReadyCycle, obsErr, obsDataOut, obsIoCycles, MEM_WAIT + 2);
        end
        checks++;
        if (ram[11'h404] !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL ds_write_ram: got %h expected 12345678", ram[11'h404]);
        end
    endtask

    task automatic test_io_read;
        runAccess(32'hffff_0003, 1'b0, 32'h0, 3, 32'h0000_00a5);
        checks++;
        if (obsIoAddr !== 4'h3 || obsIoWe !== 1'b0 || obsMemCycles != 0) begin
            errors++;
            $display("[TB] FAIL io_read_bus: got addr=%h we=%b mem=%0d expected 3/0/0",
                     obsIoAddr, obsIoWe, obsMemCycles);
        end
        checks++;
        if (obsReadyCycle != 4 || obsDataOut !== 32'h0000_00a5 || obsErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL io_read_result: got cyc=%0d data=%h err=%b expected 4/000000a5/0",
                     obsReadyCycle, obsDataOut, obsErr);
        end
    endtask

    task automatic test_io_timeout;
        runAccess(32'hffff_0007, 1'b0, 32'h0, 0, 32'h0);
        checks++;
        if (obsTimedOut || obsErr !== 1'b1 || obsDataOut !== 32'h0) begin
            errors++;
            $display("[TB] FAIL io_timeout: got hang=%0d err=%b data=%h expected 0/1/0",
                     obsTimedOut, obsErr, obsDataOut);
        end
        checks++;
        if (obsIoCycles < 1 || obsIoCycles > IO_TIMEOUT + 1 || obsReadyCycle != obsIoCycles + 1) begin
            errors++;
            $display("[TB] FAIL io_timeout_len: got ioCycles=%0d readyCycle=%0d expected <=%0d and ioCycles+1",
                     obsIoCycles, obsReadyCycle, IO_TIMEOUT + 1);
        end
        runAccess(32'hffff_000c, 1'b0, 32'h0, IO_TIMEOUT, 32'h5a5a_0f0f);
        checks++;
        if (obsErr !== 1'b0 || obsDataOut !== 32'h5a5a_0f0f || obsReadyCycle != IO_TIMEOUT + 1) begin
            errors++;
            $display("[TB] FAIL io_late_ready: got err=%b data=%h cyc=%0d expected 0/5a5a0f0f/%0d",
                     obsErr, obsDataOut, obsReadyCycle, IO_TIMEOUT + 1);
        end
    endtask

    task automatic test_unmapped;
        runAccess(32'h8000_0000, 1'b0, 32'h0, 0, 32'h0);
        checks++;
        if (obsReadyCycle != 1 || obsErr !== 1'b1 || obsDataOut !== 32'h0 ||
            obsMemCycles != 0 || obsIoCycles != 0 || !obsCleared) begin
            errors++;
            $display("[TB] FAIL unmapped: got cyc=%0d err=%b data=%h mem=%0d io=%0d cleared=%0d expected 1/1/0/0/0/1",
                     obsReadyCycle, obsErr, obsDataOut, obsMemCycles, obsIoCycles, obsCleared);
        end
    endtask

    task automatic test_abort;
        bit sawActivity;
        addressVirt = 32'h0000_0020; wEnVirt = 1'b0; dataInVirt = 32'h0; reqVirt = 1'b1;
        @(posedge clk); #1;
        reqVirt = 1'b0;
        checks++;
        if (enPhys !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_start: got enPhys=%b expected 1", enPhys);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({readyVirt, errVirt, enPhys, wEnPhys, enIO, wEnIO, dataOutVirt, addressPhys,
             dataInPhys, addressIO, dataInIO} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got ready=%b en=%b aP=%h dOut=%h expected all 0",
                     readyVirt, enPhys, addressPhys, dataOutVirt);
        end
        sawActivity = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (readyVirt !== 1'b0 || enPhys !== 1'b0) sawActivity = 1;
        end
        checks++;
        if (sawActivity) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got activity=1 expected 0");
        end
    endtask

    task automatic test_back_to_back;
        int cycA, cycB;
        logic [31:0] dataA, dataB;
        addressVirt = 32'h0000_0100; wEnVirt = 1'b0; dataInVirt = 32'h0; reqVirt = 1'b1;
        cycA = 0;
        for (int c = 1; c <= BOUND && cycA == 0; c++) begin
            @(posedge clk); #1;
            if (readyVirt === 1'b1) begin
                cycA = c; dataA = dataOutVirt;
            end
        end
        addressVirt = 32'h1000_0080;
        checks++;
        if (cycA != MEM_WAIT + 2 || dataA !== refMem[11'h100]) begin
            errors++;
            $display("[TB] FAIL b2b_first: got cyc=%0d data=%h expected %0d/%h",
                     cycA, dataA, MEM_WAIT + 2, refMem[11'h100]);
        end
        @(posedge clk); #1;
        checks++;
        if (readyVirt !== 1'b0 || enPhys !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_gap: got ready=%b enPhys=%b expected 0/0", readyVirt, enPhys);
        end
        @(posedge clk); #1;
        reqVirt = 1'b0;
        checks++;
        if (enPhys !== 1'b1 || addressPhys !== 11'h480) begin
            errors++;
            $display("[TB] FAIL b2b_second_start: got en=%b addr=%h expected 1/480", enPhys, addressPhys);
        end
        cycB = 0;
        for (int c = 2; c <= BOUND && cycB == 0; c++) begin
            @(posedge clk); #1;
            if (readyVirt === 1'b1) begin
                cycB = c; dataB = dataOutVirt;
            end
        end
        checks++;
        if (cycB != MEM_WAIT + 2 || dataB !== refMem[11'h480]) begin
            errors++;
            $display("[TB] FAIL b2b_second: got cyc=%0d data=%h expected %0d/%h",
                     cycB, dataB, MEM_WAIT + 2, refMem[11'h480]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [31:0] bounds [0:7];
        logic [31:0] addr, din, ioData, expData;
        logic we, expErr;
        logic [PAB-1:0] expPhys;
        int kind, region, readyAt, expReady;
        bounds[0] = 32'h0000_0000; bounds[1] = 32'h0fff_ffff; bounds[2] = 32'h1000_0000;
        bounds[3] = 32'h7fff_ffff; bounds[4] = 32'h8000_0000; bounds[5] = 32'hfffe_ffff;
        bounds[6] = 32'hffff_0000; bounds[7] = 32'hffff_ffff;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 2) addr = $urandom & 32'h0fff_ffff;
            else if (kind <= 5) addr = 32'h1000_0000 + ($urandom % 32'h7000_0000);
            else if (kind <= 7) addr = 32'hffff_0000 | ($urandom & 32'hffff);
            else if (kind == 8) addr = 32'h8000_0000 + ($urandom % 32'h7fff_0000);
            else addr = bounds[$urandom_range(0, 7)];
            we = 1'($urandom); din = $urandom; ioData = $urandom;
            readyAt = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, IO_TIMEOUT));
            region = regionOf(addr);
            runAccess(addr, we, din, readyAt, ioData);
            expPhys = '0;
            if (region <= 1) begin
                expPhys = physOf(addr, region);
                expReady = MEM_WAIT + 2; expErr = 1'b0;
                expData = we ? 32'h0 : refMem[expPhys];
                if (we) refMem[expPhys] = din;
                checks++;
                if (obsPhysAddr !== expPhys || obsPhysWe !== we || (we && obsPhysDin !== din) ||
                    obsMemCycles != MEM_WAIT + 1 || obsHoldBad || obsIoCycles != 0) begin
                    errors++;
                    $display("[TB] FAIL rnd_mem_bus #%0d addr=%h: got pa=%h we=%b din=%h cyc=%0d hold=%0d io=%0d expected pa=%h we=%b din=%h cyc=%0d",
                             n, addr, obsPhysAddr, obsPhysWe, obsPhysDin, obsMemCycles, obsHoldBad,
                             obsIoCycles, expPhys, we, din, MEM_WAIT + 1);
                end
            end else if (region == 2) begin
                expErr = (readyAt == 0);
                expData = (readyAt != 0 && !we) ? ioData : 32'h0;
                expReady = (readyAt != 0) ? readyAt + 1 : obsIoCycles + 1;
                checks++;
                if (obsIoAddr !== ioOf(addr) || obsIoWe !== we || (we && obsIoDin !== din) ||
                    obsMemCycles != 0 || obsIoCycles < 1 || obsIoCycles > IO_TIMEOUT + 1) begin
                    errors++;
                    $display("[TB] FAIL rnd_io_bus #%0d addr=%h: got ia=%h we=%b din=%h mem=%0d io=%0d expected ia=%h we=%b din=%h",
                             n, addr, obsIoAddr, obsIoWe, obsIoDin, obsMemCycles, obsIoCycles,
                             ioOf(addr), we, din);
                end
            end else begin
                expReady = 1; expErr = 1'b1; expData = 32'h0;
                checks++;
                if (obsMemCycles != 0 || obsIoCycles != 0) begin
                    errors++;
                    $display("[TB] FAIL rnd_unmapped_en #%0d addr=%h: got mem=%0d io=%0d expected 0/0",
                             n, addr, obsMemCycles, obsIoCycles);
                end
            end
            checks++;
            if (obsTimedOut || obsReadyCycle != expReady || obsErr !== expErr || obsDataOut !== expData) begin
                errors++;
                $display("[TB] FAIL rnd_result #%0d addr=%h we=%b: got hang=%0d cyc=%0d err=%b data=%h expected cyc=%0d err=%b data=%h",
                         n, addr, we, obsTimedOut, obsReadyCycle, obsErr, obsDataOut, expReady, expErr, expData);
            end
            checks++;
            if (!obsCleared || obsOverlap || obsEnAtReady) begin
                errors++;
                $display("[TB] FAIL rnd_protocol #%0d: got cleared=%0d overlap=%0d enAtReady=%0d expected 1/0/0",
                         n, obsCleared, obsOverlap, obsEnAtReady);
            end
        end
    endtask

    // Watchdog so a stuck run still ends with a reported failure.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2048; i++) refMem[i] = seedFn(PAB'(i));
        reqVirt = 1'b0; wEnVirt = 1'b0; addressVirt = '0; dataInVirt = '0;
        readyIO = 1'b0; dataOutIO = '0;
        test_reset();
        test_text_read();
        test_ds_write();
        test_io_read();
        test_io_timeout();
        test_unmapped();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
